// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// PS/2 host-to-device transmitter. Sends one command byte to a keyboard
// using the clock-inhibit / request-to-send handshake. The byte goes out
// LSB first, followed by an odd parity bit and a stop bit, and then the
// device ACK is checked. The PS/2 lines are open-drain. This block only
// drives active-high pull-low enables. The existing keyboard receiver
// shares the lines and must ignore traffic while busy=1.
//
// Optional feature (compile-time macro PS2_TX_RETRY_EN):
//   defined   - a NACK or timeout restarts the transfer from INHIBIT with
//               the same byte. Up to 2 retries are made, so tx_err pulses
//               only after the third failure.
//   undefined - the first failure reports tx_err.
//
// Ports:
//   clk          system clock
//   rstn         synchronous active-low reset
//   PS2_clk      PS/2 clock line level (asynchronous)
//   PS2_data     PS/2 data line level (asynchronous)
//   ps2_clk_oe   1 = pull PS/2 clock low
//   ps2_data_oe  1 = pull PS/2 data low
//   tx_data      byte to send
//   tx_valid     send request, accepted while tx_ready=1
//   tx_ready     1 only in IDLE
//   busy         1 in every state except IDLE
//   tx_done      one-cycle pulse: byte acknowledged by the device
//   tx_err       one-cycle pulse: NACK or timeout
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 10000,
   parameter int TIMEOUT_CYCLES = 2000000
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       PS2_clk,
   input  logic       PS2_data,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_err
);

   localparam int ICW = $clog2(INHIBIT_CYCLES + 1);
   localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

   // The start bit is pulled one cycle before the clock is released.
   // Both lines are therefore low together for the last inhibit cycle.
   localparam logic [ICW-1:0] INH_PRE  = ICW'(INHIBIT_CYCLES - 2);
   localparam logic [ICW-1:0] INH_LAST = ICW'(INHIBIT_CYCLES - 1);
   localparam logic [TCW-1:0] TO_LAST  = TCW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      RTS,
      SHIFT,
      ACK,
      WAIT_IDLE,
      DONE,
      ERR
   } state_t;

   state_t         state;
   logic [2:0]     clk_sync;
   logic [1:0]     data_sync;
   logic [ICW-1:0] inh_cnt;
   logic [TCW-1:0] to_cnt;
   logic [3:0]     edge_n;
   logic [3:0]     edge_next;
   logic [7:0]     shreg;
   logic           parity;
   logic           fall;
   logic           clk_s;
   logic           data_s;
   logic           timing;
   logic           fail_now;
`ifdef PS2_TX_RETRY_EN
   logic [7:0]     tx_byte;
   logic [1:0]     retry_cnt;
`endif

   // Bring both line levels into the clk domain. The sync flops reset to 1,
   // which is the idle line level, so no false falling edge appears after reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         clk_sync  <= 3'b111;
         data_sync <= 2'b11;
      end else begin
         clk_sync  <= {clk_sync[1:0], PS2_clk};
         data_sync <= {data_sync[0], PS2_data};
      end
   end

   assign fall      = clk_sync[2] & ~clk_sync[1];
   assign clk_s     = clk_sync[1];
   assign data_s    = data_sync[1];
   assign edge_next = edge_n + 4'd1;

   // The timeout window covers everything from clock release to the end
   // of the ACK. A failure is either a timeout or a high data line on the
   // ACK edge. A timeout wins over a fall that happens in the same cycle.
   always_comb begin
      timing = 1'b0;
      case (state)
         RTS, SHIFT, ACK, WAIT_IDLE: timing = 1'b1;
         default:                    timing = 1'b0;
      endcase
   end

   assign fail_now = timing & ((to_cnt == TO_LAST) | ((state == ACK) & fall & data_s));

   // Main transfer sequencer. All outputs are registered, so any line
   // change takes effect on the cycle after the edge that caused it.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state       <= IDLE;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         tx_ready    <= 1'b1;
         busy        <= 1'b0;
         tx_done     <= 1'b0;
         tx_err      <= 1'b0;
         inh_cnt     <= '0;
         to_cnt      <= '0;
         edge_n      <= '0;
         shreg       <= '0;
         parity      <= 1'b0;
`ifdef PS2_TX_RETRY_EN
         tx_byte     <= '0;
         retry_cnt   <= '0;
`endif
      end else begin
         tx_done <= 1'b0;
         tx_err  <= 1'b0;
         if (timing) begin
            to_cnt <= to_cnt + 1'b1;
         end
         if (fail_now) begin
`ifdef PS2_TX_RETRY_EN
            if (retry_cnt != 2'd2) begin
               retry_cnt   <= retry_cnt + 2'd1;
               shreg       <= tx_byte;
               inh_cnt     <= '0;
               edge_n      <= '0;
               ps2_clk_oe  <= 1'b1;
               ps2_data_oe <= 1'b0;
               state       <= INHIBIT;
            end else begin
               ps2_clk_oe  <= 1'b0;
               ps2_data_oe <= 1'b0;
               tx_err      <= 1'b1;
               state       <= ERR;
            end
`else
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_err      <= 1'b1;
            state       <= ERR;
`endif
         end else begin
            case (state)
               IDLE: begin
                  if (tx_valid) begin
                     shreg      <= tx_data;
                     parity     <= ~^tx_data;
                     inh_cnt    <= '0;
                     edge_n     <= '0;
                     ps2_clk_oe <= 1'b1;
                     tx_ready   <= 1'b0;
                     busy       <= 1'b1;
                     state      <= INHIBIT;
`ifdef PS2_TX_RETRY_EN
                     tx_byte    <= tx_data;
                     retry_cnt  <= '0;
`endif
                  end
               end
               INHIBIT: begin
                  inh_cnt <= inh_cnt + 1'b1;
                  if (inh_cnt == INH_PRE) begin
                     ps2_data_oe <= 1'b1;
                  end
                  if (inh_cnt == INH_LAST) begin
                     ps2_clk_oe <= 1'b0;
                     to_cnt     <= '0;
                     edge_n     <= '0;
                     state      <= RTS;
                  end
               end
               RTS: begin
                  if (fall) begin
                     edge_n      <= edge_next;
                     ps2_data_oe <= ~shreg[0];
                     shreg       <= shreg >> 1;
                     state       <= SHIFT;
                  end
               end
               SHIFT: begin
                  if (fall) begin
                     edge_n <= edge_next;
                     if (edge_next <= 4'd8) begin
                        ps2_data_oe <= ~shreg[0];
                        shreg       <= shreg >> 1;
                     end else if (edge_next == 4'd9) begin
                        ps2_data_oe <= ~parity;
                     end else begin
                        ps2_data_oe <= 1'b0;
                        state       <= ACK;
                     end
                  end
               end
               ACK: begin
                  if (fall) begin
                     edge_n <= edge_next;
                     state  <= WAIT_IDLE;
                  end
               end
               WAIT_IDLE: begin
                  if (clk_s & data_s) begin
                     tx_done <= 1'b1;
                     state   <= DONE;
                  end
               end
               DONE, ERR: begin
                  tx_ready <= 1'b1;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter for the keyboard port. Sends one command byte (LED set 0xED, reset 0xFF, …) to the keyboard. Uses the standard clock-inhibit / request-to-send sequence, 8 data bits LSB first, odd parity, stop bit and device ACK. Drives the open-drain PS/2 lines through active-high pull-low enables and shares the lines with the existing keyboard receiver. The receiver must ignore traffic while `busy`=1.

Parameters:
- INHIBIT_CYCLES, 10000, clk cycles the clock line is held low before request-to-send (100 us at 100 MHz).
- TIMEOUT_CYCLES, 2000000, max clk cycles from clock release to ACK completion (20 ms at 100 MHz).

Ports:
- clk  in  1  system clock
- rstn  in  1  synchronous active-low reset, sampled on rising clk
- PS2_clk  in  1  PS/2 clock line level (async)
- PS2_data  in  1  PS/2 data line level (async)
- ps2_clk_oe  out  1  1 = pull PS/2 clock low
- ps2_data_oe  out  1  1 = pull PS/2 data low
- tx_data  in  8  byte to send
- tx_valid  in  1  request; accepted when tx_ready=1
- tx_ready  out  1  1 in IDLE only
- busy  out  1  1 in any state except IDLE
- tx_done  out  1  one-cycle pulse: byte ACKed by device
- tx_err  out  1  one-cycle pulse: NACK or timeout

Behaviour:
- Synchronous active-low reset only. In reset: ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, busy=0, tx_done=0, tx_err=0, state=IDLE, counters=0.
- Input sync:
  - PS2_clk passes through a 3-flop shift register.
  - fall = stage[2] & ~stage[1].
  - PS2_data passes through a 2-flop synchronizer.
- Accept: in IDLE, tx_valid=1 latches tx_data and computes parity = ~^tx_data (odd parity). Next state is INHIBIT. tx_valid outside IDLE is ignored.
- INHIBIT:
  - ps2_clk_oe=1, ps2_data_oe=0, cycle counter runs.
  - On count INHIBIT_CYCLES-1, assert ps2_data_oe=1 (start bit) for that cycle, then go to RTS.
- RTS:
  - ps2_clk_oe=0, ps2_data_oe=1.
  - Timeout counter starts at 0 on entry.
  - Each fall increments a 4-bit edge index n (starts 0).
- SHIFT, falls n=1..8: ps2_data_oe = ~shreg[0], then shift right. Output changes on the cycle after the synchronized falling edge is detected.
- Fall n=9: ps2_data_oe = ~parity.
- Fall n=10: ps2_data_oe=0 (stop bit, line released). Go to ACK.
- ACK: on fall n=11, sample synced data.
  - data=0 → WAIT_IDLE.
  - data=1 → ERR.
- WAIT_IDLE: wait until synced clock and data both read 1, then → DONE.
- DONE: tx_done=1 for one cycle, then IDLE.
- ERR: tx_err=1 for one cycle, release both lines, then IDLE.
- Timeout: the counter runs in RTS, SHIFT, ACK and WAIT_IDLE. Reaching TIMEOUT_CYCLES → ERR. Timeout has priority over a fall in the same cycle.
- tx_done and tx_err are never asserted in the same cycle.
- Reset mid-transfer: both OEs drop to 0 on the first clk edge with rstn=0. No done/err pulse is generated.
- Counter widths: $clog2(INHIBIT_CYCLES+1) and $clog2(TIMEOUT_CYCLES+1). No wrap occurs within one transfer.

Optional Feature:
PS2_TX_RETRY_EN
- Defined: on NACK or timeout the block restarts from INHIBIT with the same byte, up to 2 retries (3 attempts total). tx_err pulses only after the third failure. busy stays 1 throughout. The retry counter is cleared on accept.
- Undefined: first failure → ERR immediately, as above.

Test Plan:
1. INHIBIT_CYCLES=100. Send 0xED; device model clocks at 10 kHz and ACKs.
   - Required: ps2_clk_oe high for 100 cycles.
   - Data bits on the line after falls 1..8 = 1,0,1,1,0,1,1,1; parity = 1; stop = released.
   - tx_done pulses once; busy returns to 0.
2. Send 0xFF with ACK.
   - Required: 8 ones, parity = 0, tx_done = 1.
   - tx_valid=1 with 0x00 mid-transfer is ignored: no second frame and no extra pulse.
3. Send 0x55 while the device leaves data high at fall 11 (NACK).
   - Required: tx_err pulses once within 2 cycles after fall 11 detection; both OEs = 0.
   - With PS2_TX_RETRY_EN: 3 INHIBIT phases occur before tx_err.
4. TIMEOUT_CYCLES=5000; device never clocks after RTS.
   - Required: tx_err exactly 5000 cycles after RTS entry; no tx_done.
5. rstn=0 for 1 cycle after fall 4 of 0xA5.
   - Required: next cycle ps2_clk_oe = ps2_data_oe = 0, tx_ready = 1, no pulses.
   - A new send of 0x0F then completes normally.
